image_upscale_stream: RTL

Inverse of the capture-side crop/downsample path: accepts a serially written 28x28 grayscale image and replays it as a full 640x480 raster stream. Each stored pixel is replicated over an SX x SY cell placed at the same window the downsampler samples from; pixels outside the window are black. It sits between the normalized-image buffer and the VGA/SPART debug output, with valid/ready backpressure on the output.

---
 rtl/image_upscale_stream.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/image_upscale_stream.sv
// Replays a serially loaded NxN grayscale image as a full raster stream, each pixel
// replicated over an SX x SY cell inside a fixed window. Optional macro: CELL_GRID_EN.
module image_upscale_stream #(
  parameter int H_ACT  = 640,
  parameter int V_ACT  = 480,
  parameter int X_INIT = 27,
  parameter int Y_INIT = 17,
  parameter int SX     = 21,
  parameter int SY     = 16,
  parameter int N      = 28,
  parameter int DW     = 12
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iCLR,
  input  logic          iWR,
  input  logic [DW-1:0] iWR_DATA,
  output logic          oFULL,
  input  logic          iSTART,
  input  logic          iREADY,
  output logic          oDVAL,
  output logic [DW-1:0] oDATA,
  output logic [9:0]    oX,
  output logic [9:0]    oY,
  output logic          oSOF,
  output logic          oEOF,
  output logic          oDONE
);

  localparam int AW = $clog2(N * N + 1);
  localparam logic [9:0]    XLO    = 10'(X_INIT);
  localparam logic [9:0]    XHI    = 10'(X_INIT + N * SX);
  localparam logic [9:0]    YLO    = 10'(Y_INIT);
  localparam logic [9:0]    YHI    = 10'(Y_INIT + N * SY);
  localparam logic [9:0]    XLAST  = 10'(H_ACT - 1);
  localparam logic [9:0]    YLAST  = 10'(V_ACT - 1);
  localparam logic [5:0]    SXLAST = 6'(SX - 1);
  localparam logic [5:0]    SYLAST = 6'(SY - 1);
  localparam logic [AW-1:0] NA     = AW'(N);
  localparam logic [AW-1:0] WLAST  = AW'(N * N - 1);

  typedef enum logic [1:0] {EMPTY, LOAD, FULL, STREAM} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] mem [N*N];
  logic [AW-1:0] wrAddr_q, wrAddr_d;
  logic          full_q, full_d, dval_q, dval_d, sof_q, sof_d, eof_q, eof_d, done_q, done_d;
  logic [DW-1:0] data_q, data_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  // Position of the next pixel to be presented, plus its cell-walk counters.
  logic [9:0]    nx_q, nx_d, ny_q, ny_d;
  logic [5:0]    subX_q, subX_d, subY_q, subY_d, col_q, col_d;
  logic [AW-1:0] rowBase_q, rowBase_d;
  logic          memWe, loadPix, xIn, yIn;
  logic [AW-1:0] addr;
  logic [DW-1:0] pixVal;

  assign xIn  = (nx_q >= XLO) && (nx_q < XHI);
  assign yIn  = (ny_q >= YLO) && (ny_q < YHI);
  assign addr = rowBase_q + AW'(col_q);

`ifdef CELL_GRID_EN
  assign pixVal = (xIn && yIn) ? (((subX_q == '0) || (subY_q == '0)) ? '1 : mem[addr]) : '0;
`else
  assign pixVal = (xIn && yIn) ? mem[addr] : '0;
`endif

  always_comb begin
    state_d = state_q;   wrAddr_d = wrAddr_q; full_d = full_q;
    dval_d = dval_q;     data_d = data_q;     x_d = x_q;       y_d = y_q;
    sof_d = sof_q;       eof_d = eof_q;       done_d = 1'b0;
    nx_d = nx_q;         ny_d = ny_q;         subX_d = subX_q; subY_d = subY_q;
    col_d = col_q;       rowBase_d = rowBase_q;
    memWe = 1'b0;        loadPix = 1'b0;
    if (iCLR) begin
      state_d = EMPTY; wrAddr_d = '0; full_d = 1'b0; dval_d = 1'b0; data_d = '0;
      x_d = '0; y_d = '0; sof_d = 1'b0; eof_d = 1'b0;
      nx_d = '0; ny_d = '0; subX_d = '0; subY_d = '0; col_d = '0; rowBase_d = '0;
    end else begin
      unique case (state_q)
        EMPTY, LOAD: if (iWR) begin
          memWe    = 1'b1;
          wrAddr_d = wrAddr_q + 1'b1;
          state_d  = LOAD;
          if (wrAddr_q == WLAST) begin
            full_d  = 1'b1;
            state_d = FULL;
          end
        end
        FULL: if (iSTART) begin
          state_d = STREAM;
          loadPix = 1'b1;
        end
        STREAM: if (dval_q && iREADY) begin
          if (eof_q) begin
            dval_d = 1'b0; sof_d = 1'b0; eof_d = 1'b0; done_d = 1'b1;
            state_d = FULL;
          end else begin
            loadPix = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
      // Present the next position, then step the raster and cell counters past it.
      if (loadPix) begin
        dval_d = 1'b1;
        data_d = pixVal;
        x_d    = nx_q;
        y_d    = ny_q;
        sof_d  = (nx_q == '0) && (ny_q == '0);
        eof_d  = (nx_q == XLAST) && (ny_q == YLAST);
        if (nx_q == XLAST) begin
          nx_d = '0; subX_d = '0; col_d = '0;
          if (ny_q == YLAST) begin
            ny_d = '0; subY_d = '0; rowBase_d = '0;
          end else begin
            ny_d = ny_q + 1'b1;
            if (yIn) begin
              if (subY_q == SYLAST) begin
                subY_d    = '0;
                rowBase_d = rowBase_q + NA;
              end else begin
                subY_d = subY_q + 1'b1;
              end
            end
          end
        end else begin
          nx_d = nx_q + 1'b1;
          if (xIn) begin
            if (subX_q == SXLAST) begin
              subX_d = '0;
              col_d  = col_q + 1'b1;
            end else begin
              subX_d = subX_q + 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (memWe) mem[wrAddr_q] <= iWR_DATA;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= EMPTY; wrAddr_q <= '0; full_q <= 1'b0; dval_q <= 1'b0; data_q <= '0;
      x_q <= '0; y_q <= '0; sof_q <= 1'b0; eof_q <= 1'b0; done_q <= 1'b0;
      nx_q <= '0; ny_q <= '0; subX_q <= '0; subY_q <= '0; col_q <= '0; rowBase_q <= '0;
    end else begin
      state_q <= state_d; wrAddr_q <= wrAddr_d; full_q <= full_d; dval_q <= dval_d; data_q <= data_d;
      x_q <= x_d; y_q <= y_d; sof_q <= sof_d; eof_q <= eof_d; done_q <= done_d;
      nx_q <= nx_d; ny_q <= ny_d; subX_q <= subX_d; subY_q <= subY_d; col_q <= col_d;
      rowBase_q <= rowBase_d;
    end
  end

  assign oFULL = full_q;
  assign oDVAL = dval_q;
  assign oDATA = data_q;
  assign oX    = x_q;
  assign oY    = y_q;
  assign oSOF  = sof_q;
  assign oEOF  = eof_q;
  assign oDONE = done_q;

endmodule
